// File: rtl/ihex_rom_loader_pkg.sv
// ============================================================================
// Module : ihex_pkg
// Brief  : Shared states, record types and ASCII codes for the HEX ROM loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ihex_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN_H = 4'd1,
        S_LEN_L = 4'd2,
        S_ADR0  = 4'd3,
        S_ADR1  = 4'd4,
        S_ADR2  = 4'd5,
        S_ADR3  = 4'd6,
        S_TYP_H = 4'd7,
        S_TYP_L = 4'd8,
        S_DAT_H = 4'd9,
        S_DAT_L = 4'd10,
        S_CK_H  = 4'd11,
        S_CK_L  = 4'd12,
        S_EOF   = 4'd13
    } state_t;

    localparam logic [7:0] REC_DATA      = 8'h00;
    localparam logic [7:0] REC_EOF       = 8'h01;
    localparam logic [7:0] REC_MAX_KNOWN = 8'h05;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/ihex_rom_loader_nibble_dec.sv
// ============================================================================
// Module : ihex_nibble_dec
// Brief  : Combinational ASCII hex digit to nibble decoder (either letter case).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ihex_nibble_dec (
    input  logic [7:0] byte_in,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            valid  = 1'b1;
            nibble = byte_in[3:0];
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 yields 10
            valid  = 1'b1;
            nibble = byte_in[3:0] + 4'd9;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ihex_rom_loader.sv
// ============================================================================
// Module : ihex_rom_loader
// Brief  : ioctl download to program-ROM byte writes; raw binary or Intel HEX.
//          Optional checksum verification when IHEX_CHECKSUM_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ihex_rom_loader
    import ihex_pkg::*;
#(
    parameter int ROM_AW  = 15,
    parameter int MAX_REC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [7:0]        dl_index,
    input  logic [ROM_AW-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              load_done,
    output logic              load_err,
    output logic              oob_seen
);

    state_t            state_q, state_d;
    logic              dl_active_q, dl_active_d;
    logic              bin_q, bin_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        typ_q, typ_d;
    logic [3:0]        hi_q, hi_d;
    logic              rom_we_q, rom_we_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        rom_data_q, rom_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              oob_q, oob_d;
`ifdef IHEX_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`else
`endif

    logic       w_nib_v;
    logic [3:0] w_nib;
    logic       w_rise, w_fall, w_bin, w_byte_v;
    logic [7:0] w_byte;
    state_t     w_cur;

    ihex_nibble_dec u_nib (
        .byte_in (dl_data),
        .valid   (w_nib_v),
        .nibble  (w_nib)
    );

    always_comb begin
        w_rise   = dl_active & ~dl_active_q;
        w_fall   = ~dl_active & dl_active_q;
        w_bin    = dl_active ? (dl_index == 8'd0) : bin_q;
        w_byte_v = dl_wr & dl_active;
        w_byte   = {hi_q, w_nib};
        // A new download starts from a clean slate even if its first byte lands now
        w_cur    = w_rise ? S_IDLE : state_q;

        state_d     = w_cur;
        dl_active_d = dl_active;
        bin_d       = w_bin;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        typ_d       = typ_q;
        hi_d        = hi_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        done_d      = w_rise ? 1'b0 : done_q;
        err_d       = w_rise ? 1'b0 : err_q;
        oob_d       = w_rise ? 1'b0 : oob_q;
`ifdef IHEX_CHECKSUM_EN
        sum_d       = sum_q;
`else
`endif

        if (w_fall) begin
            state_d = S_IDLE;
            if (bin_q)
                done_d = 1'b1;
            else if (state_q != S_EOF)
                err_d = 1'b1;
        end else if (w_bin) begin
            rom_we_d   = w_byte_v;
            rom_addr_d = dl_addr;
            rom_data_d = dl_data;
        end else if (w_byte_v && w_cur != S_EOF) begin
            if (dl_data == ASCII_COLON) begin
                if (w_cur != S_IDLE)
                    err_d = 1'b1;
                state_d = S_LEN_H;
`ifdef IHEX_CHECKSUM_EN
                sum_d   = 8'h00;
`else
`endif
            end else if (w_cur == S_IDLE) begin
                state_d = S_IDLE;
            end else if (!w_nib_v) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (w_cur)
                    S_LEN_H: begin
                        hi_d    = w_nib;
                        state_d = S_LEN_L;
                    end
                    S_LEN_L: begin
                        cnt_d = w_byte;
`ifdef IHEX_CHECKSUM_EN
                        sum_d = sum_q + w_byte;
`else
`endif
                        if (int'(w_byte) > MAX_REC) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ADR0;
                        end
                    end
                    S_ADR0, S_ADR2: begin
                        addr_d  = {addr_q[11:0], w_nib};
                        hi_d    = w_nib;
                        state_d = (w_cur == S_ADR0) ? S_ADR1 : S_ADR3;
                    end
                    S_ADR1, S_ADR3: begin
                        addr_d  = {addr_q[11:0], w_nib};
`ifdef IHEX_CHECKSUM_EN
                        sum_d   = sum_q + w_byte;
`else
`endif
                        state_d = (w_cur == S_ADR1) ? S_ADR2 : S_TYP_H;
                    end
                    S_TYP_H, S_DAT_H, S_CK_H: begin
                        hi_d    = w_nib;
                        state_d = (w_cur == S_TYP_H) ? S_TYP_L :
                                  (w_cur == S_DAT_H) ? S_DAT_L : S_CK_L;
                    end
                    S_TYP_L: begin
                        typ_d = w_byte;
`ifdef IHEX_CHECKSUM_EN
                        sum_d = sum_q + w_byte;
`else
`endif
                        if (w_byte > REC_MAX_KNOWN)
                            err_d = 1'b1;
                        state_d = (cnt_q == 8'd0) ? S_CK_H : S_DAT_H;
                    end
                    S_DAT_L: begin
`ifdef IHEX_CHECKSUM_EN
                        sum_d = sum_q + w_byte;
`else
`endif
                        if (typ_q == REC_DATA) begin
                            if ({16'd0, addr_q} < (32'd1 << ROM_AW)) begin
                                rom_we_d   = 1'b1;
                                rom_addr_d = addr_q[ROM_AW-1:0];
                                rom_data_d = w_byte;
                            end else begin
                                oob_d = 1'b1;
                            end
                        end
                        addr_d  = addr_q + 16'd1;
                        cnt_d   = cnt_q - 8'd1;
                        state_d = (cnt_q == 8'd1) ? S_CK_H : S_DAT_H;
                    end
                    S_CK_L: begin
                        state_d = S_IDLE;
`ifdef IHEX_CHECKSUM_EN
                        if (8'(sum_q + w_byte) != 8'h00) begin
                            err_d = 1'b1;
                        end else if (typ_q == REC_EOF) begin
                            done_d  = 1'b1;
                            state_d = S_EOF;
                        end
`else
                        if (typ_q == REC_EOF) begin
                            done_d  = 1'b1;
                            state_d = S_EOF;
                        end
`endif
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dl_active_q <= 1'b0;
            bin_q       <= 1'b0;
            cnt_q       <= 8'd0;
            addr_q      <= 16'd0;
            typ_q       <= 8'd0;
            hi_q        <= 4'd0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_data_q  <= 8'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            oob_q       <= 1'b0;
`ifdef IHEX_CHECKSUM_EN
            sum_q       <= 8'd0;
`else
`endif
        end else begin
            state_q     <= state_d;
            dl_active_q <= dl_active_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            typ_q       <= typ_d;
            hi_q        <= hi_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            oob_q       <= oob_d;
`ifdef IHEX_CHECKSUM_EN
            sum_q       <= sum_d;
`else
`endif
        end
    end

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_data  = rom_data_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign oob_seen  = oob_q;

endmodule

`default_nettype wire

// File: tb/tb_ihex_rom_loader.sv
// ============================================================================
// Module : tb_ihex_rom_loader
// Brief  : Self-checking bench: file-level write/flag model vs. ihex_rom_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ihex_rom_loader;
    import ihex_pkg::*;

    localparam int ROM_AW  = 15;
    localparam int MAX_REC = 200;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              dl_active = 1'b0;
    logic              dl_wr     = 1'b0;
    logic [7:0]        dl_index  = 8'd0;
    logic [ROM_AW-1:0] dl_addr   = '0;
    logic [7:0]        dl_data   = 8'd0;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              load_done, load_err, oob_seen;

    ihex_rom_loader #(.ROM_AW(ROM_AW), .MAX_REC(MAX_REC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_index  (dl_index),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .load_done (load_done),
        .load_err  (load_err),
        .oob_seen  (oob_seen)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int src;
    } wr_t;

    wr_t         exp_q[$];
    byte unsigned txt[$];
    int          badr[$];
    int          pres[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          m_eof, m_err, m_oob, m_done;
    bit          chk_en;
    bit          prev_we = 1'b0;
    wr_t         mon_e;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Every write the DUT issues must be the next one the model predicts, one cycle after its byte
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_we) begin
                if (dl_index != 8'd0)
                    chk("hex_write_spacing", int'(prev_we), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             rom_addr, rom_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", int'(rom_addr), mon_e.addr);
                    chk("write_data", int'(rom_data), mon_e.data);
                    if (mon_e.src < pres.size())
                        chk("write_latency", cyc, pres[mon_e.src] + 1);
                end
            end
            prev_we <= rom_we;
        end else begin
            prev_we <= 1'b0;
        end
    end

    function automatic void put_ch(input int c);
        txt.push_back(8'(c));
    endfunction

    function automatic void put_nib(input int n);
        if (n < 10)
            put_ch(8'h30 + n);
        else
            put_ch((($urandom % 2) != 0 ? 8'h41 : 8'h61) + n - 10);
    endfunction

    function automatic void put_hex(input int b);
        put_nib((b >> 4) & 15);
        put_nib(b & 15);
    endfunction

    function automatic void put_str(input string s);
        for (int i = 0; i < s.len(); i++)
            put_ch(int'(s[i]));
    endfunction

    // One well-formed record with random payload; the file-level model is updated alongside
    function automatic void add_rec(input int len, input int addr, input int typ, input bit bad_ck);
        int sum;
        int d;
        int a;
        int ck;
        put_ch(ASCII_COLON);
        put_hex(len);
        put_hex((addr >> 8) & 255);
        put_hex(addr & 255);
        put_hex(typ);
        sum = len + ((addr >> 8) & 255) + (addr & 255) + typ;
        for (int i = 0; i < len; i++) begin
            d = int'($urandom % 256);
            put_hex(d);
            sum += d;
            if (typ == 0 && !m_eof) begin
                a = (addr + i) & 16'hFFFF;
                if (a < (1 << ROM_AW))
                    exp_q.push_back('{a, d, txt.size() - 1});
                else
                    m_oob = 1'b1;
            end
        end
        ck = (256 - (sum & 255)) & 255;
        if (bad_ck)
            ck = (ck ^ (1 + int'($urandom % 255))) & 255;
        put_hex(ck);
        if (!m_eof) begin
            if (typ > 5)
                m_err = 1'b1;
            if (bad_ck && chk_en)
                m_err = 1'b1;
            if (typ == 1 && !(bad_ck && chk_en)) begin
                m_done = 1'b1;
                m_eof  = 1'b1;
            end
        end
        if (($urandom % 2) != 0)
            put_ch(ASCII_CR);
        put_ch(ASCII_LF);
    endfunction

    function automatic void add_bin(input int n);
        int d;
        int a;
        for (int i = 0; i < n; i++) begin
            d = int'($urandom % 256);
            a = int'($urandom % (1 << ROM_AW));
            put_ch(d);
            badr.push_back(a);
            exp_q.push_back('{a, d, i});
        end
        m_done = 1'b1;
    endfunction

    task automatic run_dl(input int idx, input int gmax);
        pres.delete();
        @(negedge clk);
        dl_index  = 8'(idx);
        dl_active = 1'b1;
        foreach (txt[i]) begin
            dl_wr   = 1'b1;
            dl_data = txt[i];
            dl_addr = (idx == 0) ? ROM_AW'(badr[i]) : ROM_AW'($urandom);
            pres.push_back(cyc);
            @(negedge clk);
            dl_wr = 1'b0;
            if (i == 0) begin
                chk("start_done_clear", int'(load_done), 0);
                chk("start_err_clear", int'(load_err), 0);
                chk("start_oob_clear", int'(oob_seen), 0);
            end
            repeat ($urandom_range(gmax, 0)) @(negedge clk);
        end
        dl_active = 1'b0;
        repeat (3) @(negedge clk);
        if (idx != 0 && !m_eof)
            m_err = 1'b1;
        chk("load_done", int'(load_done), int'(m_done));
        chk("load_err", int'(load_err), int'(m_err));
        chk("oob_seen", int'(oob_seen), int'(m_oob));
        chk("writes_outstanding", exp_q.size(), 0);
        exp_q.delete();
        txt.delete();
        badr.delete();
        m_eof  = 1'b0;
        m_err  = 1'b0;
        m_oob  = 1'b0;
        m_done = 1'b0;
    endtask

    initial begin
        int n;
        int typ;
        int len;
        int adr;
        int p;
`ifdef IHEX_CHECKSUM_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        m_eof = 1'b0; m_err = 1'b0; m_oob = 1'b0; m_done = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_rom_we", int'(rom_we), 0);
        chk("reset_done", int'(load_done), 0);
        chk("reset_err", int'(load_err), 0);
        chk("reset_oob", int'(oob_seen), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Binary pass-through, back-to-back bytes
        put_ch(8'h0C); badr.push_back(0);
        put_ch(8'h94); badr.push_back(1);
        exp_q.push_back('{0, 8'h0C, 0});
        exp_q.push_back('{1, 8'h94, 1});
        m_done = 1'b1;
        run_dl(0, 0);

        // Two data bytes then EOF
        put_str(":020000000C945E\n:00000001FF\n");
        exp_q.push_back('{0, 8'h0C, 10});
        exp_q.push_back('{1, 8'h94, 12});
        m_done = 1'b1; m_eof = 1'b1;
        run_dl(1, 2);

        // Truncated file: the write stands, no EOF means error
        put_str(":0100000000FF\r\n");
        exp_q.push_back('{0, 8'h00, 10});
        run_dl(2, 1);

        // Wrong checksum on a data record
        put_str(":0100000000FE\n:00000001FF\n");
        exp_q.push_back('{0, 8'h00, 10});
        m_done = 1'b1; m_eof = 1'b1; m_err = chk_en;
        run_dl(3, 1);

        // Address 0x8000 is beyond a 32 KiB ROM
        put_str(":01800000AAD5\n:00000001FF\n");
        m_oob = 1'b1; m_done = 1'b1; m_eof = 1'b1;
        run_dl(4, 1);

        // Non-hex character mid-record, then resync on EOF
        put_str(":0200G0\n:00000001FF\n");
        m_err = 1'b1; m_done = 1'b1; m_eof = 1'b1;
        run_dl(5, 0);

        // 16-bit wrap: 0xFFFF dropped, 0x0000 written
        put_str(":02FFFF001122CD\n:00000001FF\n");
        exp_q.push_back('{0, 8'h22, 12});
        m_oob = 1'b1; m_done = 1'b1; m_eof = 1'b1;
        run_dl(6, 1);

        // ':' before the checksum restarts the record
        put_str(":03001000AB:00000001FF\n");
        exp_q.push_back('{16'h0010, 8'hAB, 10});
        m_err = 1'b1; m_done = 1'b1; m_eof = 1'b1;
        run_dl(7, 1);

        // Length one above MAX_REC is rejected
        put_str(":C9000000\n:00000001FF\n");
        m_err = 1'b1; m_done = 1'b1; m_eof = 1'b1;
        run_dl(8, 0);

        // Length exactly MAX_REC straddling the ROM top, then an unknown type
        add_rec(MAX_REC, 16'h7FA0, 0, 1'b0);
        add_rec(2, 16'h0100, 7, 1'b0);
        add_rec(0, 0, 1, 1'b0);
        run_dl(9, 0);

        for (int f = 0; f < 30; f++) begin
            if (($urandom % 4) == 0) begin
                add_bin(1 + int'($urandom % 16));
                run_dl(0, 2);
            end else begin
                n = 1 + int'($urandom % 5);
                for (int r = 0; r < n; r++) begin
                    p = int'($urandom % 10);
                    typ = (p == 6) ? 2 + int'($urandom % 4) :
                          (p == 7) ? 6 + int'($urandom % 250) : 0;
                    len = int'($urandom % 9);
                    p = int'($urandom % 3);
                    adr = (p == 0) ? int'($urandom % 65536) :
                          (p == 1) ? 16'h7FF8 + int'($urandom % 8) :
                                     16'hFFFC + int'($urandom % 4);
                    add_rec(len, adr, typ, ($urandom % 8) == 0);
                end
                if (($urandom % 4) != 0)
                    add_rec(0, 0, 1, ($urandom % 6) == 0);
                if (($urandom % 2) != 0)
                    add_rec(2, int'($urandom % 256), 0, 1'b0);
                run_dl(1 + int'($urandom % 255), 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
